serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It time-shares one one-bit full-adder cell, instantiated as `full_adder` with ports A, B, C_in, S and C_out, to add two WIDTH-bit operands, processing one bit per clock from the LSB up. It latches the operands on a start/busy/done handshake, sequences the cell through WIDTH cycles with a registered carry, then presents a held result. It sits as the arithmetic sequencer in the comp-arch datapath, trading area for latency.

Parameters:
- WIDTH, 8: operand/result width in bits. Legal range is 1 to 32.
- CNT_W, 5: bit-counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk, input, 1: rising-edge clock. One clock domain.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request an add. Sampled only in IDLE.
- A, input, WIDTH: operand A. Captured on an accepted start.
- B, input, WIDTH: operand B. Captured on an accepted start.
- C_in, input, 1: carry-in. Captured on an accepted start.
- busy, output, 1: high while an operation is in progress (LOAD/RUN).
- done, output, 1: one-cycle pulse when S/C_out/overflow update.
- S, output, WIDTH: sum. Held until the next done.
- C_out, output, 1: carry out of the MSB. Held.
- overflow, output, 1: signed overflow = carry into MSB XOR C_out. Held.

Behaviour:
- Reset: on rst=1, asynchronously force state=IDLE, busy=0, done=0, S=0, C_out=0, overflow=0, counter=0, carry register=0 and shift registers=0. Reset takes effect mid-operation too; the operation in flight is abandoned and no done is produced.
- Registers: states are IDLE, RUN and DONE (2-bit encoding). Registered outputs only.
- IDLE:
  - busy=0, done=0.
  - start=1 at edge k: load the A and B shift registers, load carry_reg=C_in, set counter=0, go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1.
  - Each edge: the cell computes on (A_sh[0], B_sh[0], carry_reg). Its sum shifts into the MSB of the S shift register. carry_reg takes the cell's carry out. A_sh and B_sh shift right by 1. counter increments.
  - On the edge where counter==WIDTH-1, also capture prev_carry = carry_reg (the carry into the MSB) before the update.
  - The edge that processes bit WIDTH-1 is edge k+WIDTH. On that edge go to DONE, load S from the final shift value, set C_out = final carry and set overflow = prev_carry XOR final carry.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - Next edge: return to IDLE. done falls.
- Latency: start accepted at edge k gives done high in the cycle after edge k+WIDTH. Throughput is one add per WIDTH+2 cycles.
- Output hold: S, C_out and overflow change only on entry to DONE. The internal shift register is separate, so S never shows partial sums.
- Start rules:
  - start is ignored in RUN and DONE. It is neither queued nor a cause of error.
  - A held-high start relaunches on the first IDLE cycle.
- Operand isolation: changes on A, B or C_in after acceptance do not affect the operation in flight.
- Arithmetic: {C_out,S} = A + B + C_in, computed modulo 2^(WIDTH+1).
- WIDTH=1: a single RUN cycle. prev_carry = C_in, so overflow = C_in XOR C_out.
- Counter: never exceeds WIDTH-1. It resets to 0 on each accepted start.
- Simultaneous rst and start: rst wins.

Test Plan:
All scenarios use WIDTH=8.
- Zero add: after rst, A=00, B=00, C_in=0 with start pulsed at edge k -> busy high for 8 cycles; done pulses in the cycle after edge k+8; S=00, C_out=0, overflow=0.
- Unsigned carry: A=FF, B=01, C_in=0 -> S=00, C_out=1, overflow=0.
- Signed overflow: A=7F, B=01, C_in=0 -> S=80, C_out=0, overflow=1. Then A=80, B=80 -> S=00, C_out=1, overflow=1.
- Carry-in path: A=FF, B=FF, C_in=1 -> S=FF, C_out=1, overflow=0. S must hold its previous value until done rises.
- Ignore/isolation: start A=0F, B=01; at RUN cycle 3, pulse start and change A=AA, B=55 -> exactly one done, with S=10, C_out=0. The next start in IDLE then computes AA+55: S=FF, C_out=0.
- Reset mid-op: start A=F0, B=0F; assert rst asynchronously during RUN cycle 4 -> busy, done, S, C_out and overflow go to 0 immediately, and no done follows. After release, start A=12, B=34 -> S=46, C_out=0.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// serial_adder_ctrl_if : start/busy/done handshake and operand/result bus
// Rev 1.0
// ============================================================================
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             overflow;

  modport master (
    output start, A, B, C_in,
    input  busy, done, S, C_out, overflow
  );

  modport slave (
    input  start, A, B, C_in,
    output busy, done, S, C_out, overflow
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// serial_adder_ctrl : bit-serial adder sequencing one shared full-adder cell
// Rev 1.0
// ============================================================================
module full_adder (
  input  wire logic A,
  input  wire logic B,
  input  wire logic C_in,
  output logic      S,
  output logic      C_out
);
  assign S     = A ^ B ^ C_in;
  assign C_out = (A & B) | (C_in & (A ^ B));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input wire logic            clk,
  input wire logic            rst,
  serial_adder_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_c_out;
  logic             r_ovf;
  logic             w_sum;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_s_shift;

  full_adder u_cell (
    .A     (r_a_sh[0]),
    .B     (r_b_sh[0]),
    .C_in  (r_carry),
    .S     (w_sum),
    .C_out (w_cout)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_s_shift = w_sum;
    end else begin : g_wn
      assign w_s_shift = {w_sum, r_s_sh[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a_sh  <= bus.A;
            r_b_sh  <= bus.B;
            r_carry <= bus.C_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_s_sh  <= w_s_shift;
          r_carry <= w_cout;
          if (w_last) begin
            // r_carry here is the carry into the MSB, which sets signed overflow
            r_s     <= w_s_shift;
            r_c_out <= w_cout;
            r_ovf   <= r_carry ^ w_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: r_done <= 1'b0;
        default: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.S        = r_s;
  assign bus.C_out    = r_c_out;
  assign bus.overflow = r_ovf;
endmodule
`default_nettype wire
